// File: rtl/uart_tx_serializer.sv
// UART transmitter: edge-triggered byte request, 1-deep pending slot, optional parity, 1/2 stop bits.
// Line goes low one clock after an accepted edge; a byte arriving mid-frame waits in the pending slot.
`timescale 1ns/1ps
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

module uart_tx_serializer #(
  parameter int P_CLKS_PER_BIT = 868,
  parameter int P_PARITY_EN    = 0,
  parameter int P_PARITY_ODD   = 0,
  parameter int P_STOP_BITS    = 1
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic                        i_user_tx_valid,
  input  logic [`UART_DATA_WIDTH-1:0] i_user_tx_data,
  output logic                        o_user_tx_ready,
  output logic                        o_uart_tx,
  output logic                        o_tx_busy
);

  localparam int DW = `UART_DATA_WIDTH;
  localparam int CW = (P_CLKS_PER_BIT > 1) ? $clog2(P_CLKS_PER_BIT) : 1;
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(P_CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DW - 1);
  localparam logic STOP_LAST = (P_STOP_BITS == 2);
  localparam logic PAR_ODD   = (P_PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            stop_q, stop_d;
  logic [DW-1:0]   frame_dat_q, frame_dat_d;
  logic [DW-1:0]   hold_dat_q, hold_dat_d;
  logic            pend_q, pend_d;
  logic            tx_q, tx_d;
  logic            valid_q;
  logic            rise;
  logic            bit_end;
  logic            frame_done;

  assign rise    = i_user_tx_valid & ~valid_q;
  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    frame_dat_d = frame_dat_q;
    hold_dat_d  = hold_dat_q;
    pend_d      = pend_q;
    frame_done  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d     = START;
          frame_dat_d = i_user_tx_data;
          baud_d      = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          stop_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = (P_PARITY_EN != 0) ? PARITY : STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) frame_done = 1'b1;
          else                     stop_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An edge landing on the completion clock outranks the held byte, like a last write.
    if (frame_done) begin
      stop_d = 1'b0;
      idx_d  = '0;
      if (pend_q || rise) begin
        state_d     = START;
        frame_dat_d = rise ? i_user_tx_data : hold_dat_q;
        pend_d      = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end else if (rise && (state_q != IDLE)) begin
      pend_d     = 1'b1;
      hold_dat_d = i_user_tx_data;
    end
  end

  // Line value is decoded from the next state so it changes exactly on the bit boundary.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = frame_dat_d[idx_d];
      PARITY:  tx_d = (^frame_dat_d) ^ PAR_ODD;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      frame_dat_q <= '0;
      hold_dat_q  <= '0;
      pend_q      <= 1'b0;
      tx_q        <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      frame_dat_q <= frame_dat_d;
      hold_dat_q  <= hold_dat_d;
      pend_q      <= pend_d;
      tx_q        <= tx_d;
      valid_q     <= i_user_tx_valid;
    end
  end

  assign o_uart_tx       = tx_q;
  assign o_user_tx_ready = (state_q == IDLE) & ~pend_q;
  assign o_tx_busy       = (state_q != IDLE) | pend_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations share one stimulus stream; per-instance
// line decoders and ready-window monitors consume a scoreboard of expected bytes and frame groups.
`timescale 1ns/1ps
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] data;
  wire  [3:0] ready;
  wire  [3:0] line;
  wire  [3:0] busy;
  logic       fin = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_bytes[$];
  int         exp_grp[$];

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // u0: no parity, 1 stop; u1: even parity; u2: odd parity; u3: no parity, 2 stops
  for (genvar g = 0; g < 4; g++) begin : gen_u
    localparam int PE  = (g == 1 || g == 2) ? 1 : 0;
    localparam int ODD = (g == 2) ? 1 : 0;
    localparam int ST  = (g == 3) ? 2 : 1;
    localparam int NB  = 1 + 8 + PE + ST;
    localparam int FL  = NB * CPB;

    uart_tx_serializer #(
      .P_CLKS_PER_BIT (CPB),
      .P_PARITY_EN    (PE),
      .P_PARITY_ODD   (ODD),
      .P_STOP_BITS    (ST)
    ) u_dut (
      .S_AXI_ACLK      (clk),
      .S_AXI_ARESETN   (rst_n),
      .i_user_tx_valid (valid),
      .i_user_tx_data  (data),
      .o_user_tx_ready (ready[g]),
      .o_uart_tx       (line[g]),
      .o_tx_busy       (busy[g])
    );

    int          byte_ptr = 0;
    int          grp_ptr  = 0;
    logic [11:0] fr;
    int          bad;
    bit          ab;
    logic [7:0]  eb;
    int          rlen;
    bit          rin = 1'b0;

    always begin : dec
      @(negedge clk);
      if (rst_n && line[g] === 1'b0) begin
        ab  = 1'b0;
        bad = 0;
        fr  = '0;
        for (int s = 0; s < FL; s++) begin
          if (s > 0) begin
            @(negedge clk);
            if (!rst_n) begin
              ab = 1'b1;
              break;
            end
          end
          if (s % CPB == 0)              fr[s / CPB] = line[g];
          else if (line[g] !== fr[s / CPB]) bad++;
        end
        if (!ab) begin
          chk_eq($sformatf("u%0d_bit_hold", g), bad, 0);
          chk_eq($sformatf("u%0d_start_bit", g), fr[0], 1'b0);
          if (byte_ptr < exp_bytes.size()) begin
            eb = exp_bytes[byte_ptr];
            chk_eq($sformatf("u%0d_byte", g), fr[8:1], eb);
            if (PE != 0) chk_eq($sformatf("u%0d_parity", g), fr[9], (^eb) ^ (ODD != 0));
            byte_ptr++;
          end else begin
            chk_eq($sformatf("u%0d_extra_frame", g), byte_ptr + 1, exp_bytes.size());
          end
          for (int i = 0; i < ST; i++) chk_eq($sformatf("u%0d_stop_bit", g), fr[9 + PE + i], 1'b1);
        end
      end
    end

    always begin : rmon
      @(negedge clk);
      if (!rst_n) begin
        rin = 1'b0;
      end else if (ready[g] === 1'b0) begin
        if (!rin) begin
          rin  = 1'b1;
          rlen = 0;
          chk_eq($sformatf("u%0d_busy_at_start", g), busy[g], 1'b1);
          chk_eq($sformatf("u%0d_line_at_start", g), line[g], 1'b0);
        end
        rlen++;
      end else if (rin) begin
        rin = 1'b0;
        chk_eq($sformatf("u%0d_busy_at_end", g), busy[g], 1'b0);
        if (grp_ptr < exp_grp.size()) begin
          chk_eq($sformatf("u%0d_ready_low_len", g), rlen, exp_grp[grp_ptr] * FL);
          grp_ptr++;
        end else begin
          chk_eq($sformatf("u%0d_extra_busy", g), grp_ptr + 1, exp_grp.size());
        end
      end
    end

    always @(posedge fin) begin
      chk_eq($sformatf("u%0d_frames_seen", g), byte_ptr, exp_bytes.size());
      chk_eq($sformatf("u%0d_windows_seen", g), grp_ptr, exp_grp.size());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic [7:0] d);
    data  = d;
    valid = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    cyc(1);
    do begin
      @(negedge clk);
      n++;
    end while ((ready !== 4'hF || busy !== 4'h0) && n < 1000);
    if (ready !== 4'hF || busy !== 4'h0) chk_eq("idle_timeout", {busy, ready}, 8'h0F);
    cyc(2);
  endtask

  task automatic send(input logic [7:0] d);
    exp_bytes.push_back(d);
    exp_grp.push_back(1);
    raise(d);
    cyc(5);
    valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    cyc(3);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("u%0d_rst_line", i), line[i], 1'b1);
      chk_eq($sformatf("u%0d_rst_ready", i), ready[i], 1'b1);
      chk_eq($sformatf("u%0d_rst_busy", i), busy[i], 1'b0);
    end
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    send(8'h55);
    send(8'hA3);
    send(8'hFF);

    // second edge mid-frame goes out back-to-back
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22);
    exp_grp.push_back(2);
    raise(8'h11);
    cyc(5);
    valid = 1'b0;
    cyc(5);
    raise(8'h22);
    wait_idle();
    valid = 1'b0;
    cyc(2);

    // two edges while pending: only the last byte is sent
    exp_bytes.push_back(8'h81);
    exp_bytes.push_back(8'h99);
    exp_grp.push_back(2);
    raise(8'h81);
    cyc(5);
    valid = 1'b0;
    cyc(5);
    raise(8'h42);
    cyc(5);
    valid = 1'b0;
    cyc(5);
    raise(8'h99);
    cyc(3);
    valid = 1'b0;
    wait_idle();

    // held level yields a single frame
    exp_bytes.push_back(8'h7E);
    exp_grp.push_back(1);
    raise(8'h7E);
    cyc(100);
    valid = 1'b0;
    wait_idle();

    // edge on the completion clock of the 40-cycle instance
    exp_bytes.push_back(8'hC5);
    exp_bytes.push_back(8'h3A);
    exp_grp.push_back(2);
    raise(8'hC5);
    cyc(39);
    valid = 1'b0;
    cyc(1);
    raise(8'h3A);
    cyc(3);
    valid = 1'b0;
    wait_idle();

    // reset mid-frame: byte is dropped
    raise(8'h5A);
    cyc(15);
    rst_n = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("u%0d_abort_line", i), line[i], 1'b1);
      chk_eq($sformatf("u%0d_abort_ready", i), ready[i], 1'b1);
      chk_eq($sformatf("u%0d_abort_busy", i), busy[i], 1'b0);
    end
    cyc(2);
    rst_n = 1'b1;
    wait_idle();
    send(8'h0F);

    // valid already high at reset release counts as an edge
    rst_n = 1'b0;
    exp_bytes.push_back(8'h3C);
    exp_grp.push_back(1);
    raise(8'h3C);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)));

    fin = 1'b1;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter P_CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (legal range >= 2; 868 = 100 MHz / 115200).
REQ-002 SHALL have parameter P_PARITY_EN, default 0, meaning 1 inserts a parity bit after the data bits.
REQ-003 SHALL have parameter P_PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity; ignored when P_PARITY_EN=0.
REQ-004 SHALL have parameter P_STOP_BITS, default 1, meaning the number of stop bits (legal values 1 or 2).
REQ-005 SHALL have port S_AXI_ACLK  input  1  the single clock.
REQ-006 SHALL have port S_AXI_ARESETN  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_user_tx_valid  input  1  byte-available level from the register block.
REQ-008 SHALL have port i_user_tx_data  input  `UART_DATA_WIDTH  byte to send.
REQ-009 SHALL have port o_user_tx_ready  output  1  high only in IDLE with nothing pending.
REQ-010 SHALL have port o_uart_tx  output  1  serial line, idle high.
REQ-011 SHALL have port o_tx_busy  output  1  high while a frame is in progress or a byte is pending.

Function
REQ-012 SHALL register i_user_tx_valid once and treat only a rising edge (valid=1, previous=0) as a new request; a held-high level SHALL produce exactly one frame.
REQ-013 On a rising edge in IDLE, the block SHALL latch i_user_tx_data and enter START on the next clock; o_uart_tx SHALL be 0 and o_user_tx_ready SHALL be 0 from that clock.
REQ-014 SHALL implement states IDLE -> START -> DATA -> PARITY (only if P_PARITY_EN=1) -> STOP -> IDLE.
REQ-015 Every bit, including each stop bit, SHALL last exactly P_CLKS_PER_BIT cycles, timed by a baud counter that runs 0..P_CLKS_PER_BIT-1 and restarts at 0 on each bit boundary.
REQ-016 DATA SHALL shift bits LSB first, using a bit index 0..`UART_DATA_WIDTH-1, and SHALL advance after index `UART_DATA_WIDTH-1 completes.
REQ-017 The parity bit SHALL be the XOR of all latched data bits for even parity, and its inverse for odd parity.
REQ-018 STOP SHALL drive o_uart_tx=1 for P_STOP_BITS bit periods.
REQ-019 Frame length SHALL be (1+`UART_DATA_WIDTH+P_PARITY_EN+P_STOP_BITS)*P_CLKS_PER_BIT cycles.
REQ-020 o_user_tx_ready SHALL rise the clock after the last stop-bit cycle; this rising edge is the completion indication the register block uses to drop its valid.
REQ-021 A rising edge of valid outside IDLE SHALL set a one-deep pending flag and latch the data into a holding register.
REQ-022 A further rising edge while pending is already set SHALL overwrite the held data (last write wins) and SHALL NOT be counted as a second request.
REQ-023 With pending set, STOP completion SHALL go directly to START (no idle cycle), clear pending, and keep o_user_tx_ready=0.
REQ-024 A rising edge on the same clock the frame completes SHALL be handled as in IDLE (new frame, no loss).
REQ-025 o_uart_tx SHALL be driven from a flop and SHALL be glitch-free.
REQ-026 i_user_tx_data SHALL be ignored except on accepted or pending edges.

Reset
REQ-027 While S_AXI_ARESETN=0 at a clock edge, outputs SHALL be o_uart_tx=1, o_user_tx_ready=1 and o_tx_busy=0; state SHALL be IDLE; all counters, the pending flag and the data registers SHALL be 0; the valid history SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; the line SHALL be high on the next clock and the aborted byte SHALL NOT be resent.
REQ-029 A valid already high at reset release SHALL count as a rising edge.

Verification (P_CLKS_PER_BIT=4)
REQ-030 Case 1: 0x55, no parity, 1 stop -> o_uart_tx = 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; ready low for exactly 40 cycles.
REQ-031 Case 2: 0xA3, P_PARITY_EN=1, even parity -> data bits 1,1,0,0,0,1,0,1, parity 0, frame of 44 cycles; with P_PARITY_ODD=1, parity 1.
REQ-032 Case 3: valid rises on 0x11, then falls and rises on 0x22 at cycle 10 -> frame 0x22 starts immediately after frame 0x11's stop bit; ready stays low for 80 cycles.
REQ-033 Case 4: valid held high for 100 cycles with 0x7E -> exactly one frame; ready rises at cycle 41; no second start bit.
REQ-034 Case 5: reset asserted at cycle 15 of a frame -> line is 1 the next cycle and ready=1; after release, the next 0x0F edge produces a correct full frame.
REQ-035 Case 6: P_STOP_BITS=2, 0xFF -> line is low for 4 cycles then high for 40 cycles; ready rises after 44 cycles.
